// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared types and constants for the RV32I execute stage.
//               alu_op_e  - 4-bit ALU operation code (codes 10..15 unused,
//                           they produce a zero result).
//               SHAMT_W   - width of the shift amount taken from operand B.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam int SHAMT_W = 5;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/ex_stage_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : shift_left / shift_right_logic / shift_right_arith / alu_core
// Description : Combinational RV32I ALU. The three shifter blocks are kept as
//               separate units so they can be swapped for custom shifter
//               implementations without touching the op mux.
// Ports (alu_core):
//   op_i     in  4     ALU operation (alu_op_e)
//   a_i      in  XLEN  operand A
//   b_i      in  XLEN  operand B
//   result_o out XLEN  ALU result
// Revision    : 1.0 - initial release
// ============================================================================

module shift_left
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [XLEN-1:0]    data_o
);
    assign data_o = data_i << shamt_i;
endmodule : shift_left

module shift_right_logic
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [XLEN-1:0]    data_o
);
    assign data_o = data_i >> shamt_i;
endmodule : shift_right_logic

module shift_right_arith
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [XLEN-1:0]    data_o
);
    // Arithmetic shift on a signed view replicates the sign bit.
    assign data_o = $unsigned($signed(data_i) >>> shamt_i);
endmodule : shift_right_arith

module alu_core
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    // Only the low SHAMT_W bits of B reach the shifters; the upper bits are
    // dropped here so e.g. B=0x25 shifts by 5.
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    sll_res;
    logic [XLEN-1:0]    srl_res;
    logic [XLEN-1:0]    sra_res;
    logic               lt_signed;
    logic               lt_unsigned;

    assign shamt       = b_i[SHAMT_W-1:0];
    assign lt_signed   = $signed(a_i) < $signed(b_i);
    assign lt_unsigned = a_i < b_i;

    shift_left #(
        .XLEN    (XLEN)
    ) u_sll (
        .data_i  (a_i),
        .shamt_i (shamt),
        .data_o  (sll_res)
    );

    shift_right_logic #(
        .XLEN    (XLEN)
    ) u_srl (
        .data_i  (a_i),
        .shamt_i (shamt),
        .data_o  (srl_res)
    );

    shift_right_arith #(
        .XLEN    (XLEN)
    ) u_sra (
        .data_i  (a_i),
        .shamt_i (shamt),
        .data_o  (sra_res)
    );

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = sll_res;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = srl_res;
            ALU_SRA:  result_o = sra_res;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            // Unassigned codes still flow through the pipeline with result 0.
            default:  result_o = '0;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Registered RV32I execute stage. Resolves rs1/rs2 forwarding
//               (EX/MEM register first, then writeback), selects operand B,
//               runs the ALU and holds the result in the EX/MEM register with
//               valid/ready flow control, stall and flush.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   in_valid_i / in_ready_o         ID/EX handshake
//   alu_op_i                        ALU operation (alu_op_e)
//   rs1/rs2_addr_i, rs1/rs2_data_i  source registers and RF read data
//   imm_i, use_imm_i                immediate and operand-B select
//   rd_addr_i, rd_wen_i             destination register
//   wb_wen_i/wb_rd_addr_i/wb_data_i writeback forwarding source
//   flush_i                         kill held and incoming instruction
//   out_valid_o / out_ready_i       EX/MEM handshake
//   result_o, rd_addr_o, rd_wen_o   registered EX/MEM outputs
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,   // only 32 is supported
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  alu_op_e           alu_op_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              use_imm_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rd_wen_i,
    input  logic              wb_wen_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              rd_wen_o
);

    // EX/MEM register
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q,    result_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic              rd_wen_q,    rd_wen_d;

    logic [XLEN-1:0]   rs1_fwd;
    logic [XLEN-1:0]   rs2_fwd;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   alu_res;
    logic              capture;

    // Forwarding select for one source. x0 is hard-wired to zero and never
    // forwarded. The EX/MEM value is the younger one, so it beats WB.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [XLEN-1:0]   rf_data,
        input logic              ex_vld,
        input logic              ex_wen,
        input logic [REG_AW-1:0] ex_rd,
        input logic [XLEN-1:0]   ex_data,
        input logic              wb_wen,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_data
    );
        logic [XLEN-1:0] val;
        if (src == '0) begin
            val = '0;
        end else if (ex_vld && ex_wen && (ex_rd == src)) begin
            val = ex_data;
        end else if (wb_wen && (wb_rd == src)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // The EX/MEM register is not rewritten while stalled, so forwarding from
    // it during a stall always sees a stable value.
    always_comb begin
        rs1_fwd = fwd_sel(rs1_addr_i, rs1_data_i, out_valid_q, rd_wen_q,
                          rd_addr_q, result_q, wb_wen_i, wb_rd_addr_i, wb_data_i);
        rs2_fwd = fwd_sel(rs2_addr_i, rs2_data_i, out_valid_q, rd_wen_q,
                          rd_addr_q, result_q, wb_wen_i, wb_rd_addr_i, wb_data_i);
    end

    assign op_b = use_imm_i ? imm_i : rs2_fwd;

    alu_core #(
        .XLEN     (XLEN)
    ) u_alu_core (
        .op_i     (alu_op_i),
        .a_i      (rs1_fwd),
        .b_i      (op_b),
        .result_o (alu_res)
    );

    // Ready depends only on the register state and downstream ready; flush
    // deliberately does not gate it.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign capture    = in_valid_i && in_ready_o && !flush_i;

    // Two-state occupancy (EMPTY/FULL) encoded directly in out_valid_q.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rd_addr_d   = rd_addr_q;
        rd_wen_d    = rd_wen_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (capture) begin
            result_d  = alu_res;
            rd_addr_d = rd_addr_i;
            // A write to x0 is architecturally a no-op; drop it here so later
            // stages and the forwarding path never see it.
            rd_wen_d  = rd_wen_i && (rd_addr_i != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_addr_q   <= '0;
            rd_wen_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_addr_q   <= rd_addr_d;
            rd_wen_q    <= rd_wen_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_wen_o    = rd_wen_q;

endmodule : ex_stage
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage. Stimulus pushes expected
//               EX/MEM contents into a queue; a monitor pops and compares on
//               every output transfer (out_valid_o && out_ready_i).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    import ex_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    alu_op_e     alu_op;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        wb_wen;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;
    logic        rd_wen_out;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    ex_stage #(
        .XLEN         (32),
        .REG_AW       (5)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .alu_op_i     (alu_op),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .imm_i        (imm),
        .use_imm_i    (use_imm),
        .rd_addr_i    (rd_addr),
        .rd_wen_i     (rd_wen),
        .wb_wen_i     (wb_wen),
        .wb_rd_addr_i (wb_rd_addr),
        .wb_data_i    (wb_data),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .result_o     (result),
        .rd_addr_o    (rd_addr_out),
        .rd_wen_o     (rd_wen_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares each transferred EX/MEM entry against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got result 0x%08h rd %0d, expected no transfer",
                             result, rd_addr_out);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("rd_addr", {27'd0, rd_addr_out}, {27'd0, e.rd});
                    check("rd_wen", {31'd0, rd_wen_out}, {31'd0, e.wen});
                end
            end
        end
    end

    // Drive a bundle and hold it until the stage accepts it. Returns at
    // posedge+1 after acceptance with in_valid deasserted.
    task automatic send(input alu_op_e op,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input logic [31:0] im, input logic ui,
                        input logic [4:0] rd, input logic wen,
                        input logic [31:0] exp_res, input bit push);
        int n;
        exp_t e;
        alu_op   = op;
        rs1_addr = a1;  rs1_data = d1;
        rs2_addr = a2;  rs2_data = d2;
        imm      = im;  use_imm  = ui;
        rd_addr  = rd;  rd_wen   = wen;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        if (push) begin
            e.res = exp_res;
            e.rd  = rd;
            e.wen = wen && (rd != 5'd0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: out_valid stayed 1, expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_op = ALU_ADD;
        rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0;
        imm = '0; use_imm = 1'b0; rd_addr = '0; rd_wen = 1'b0;
        wb_wen = 1'b0; wb_rd_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_addr", {27'd0, rd_addr_out}, 32'd0);
        check("rst_rd_wen", {31'd0, rd_wen_out}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SRA sign replication, then one-cycle latency
        send(ALU_SRA, 5'd4, 32'h8000_0000, 5'd0, 32'h0, 32'h1F, 1'b1, 5'd4, 1'b1, 32'hFFFF_FFFF, 1);
        #1 check("sra_latency_valid", {31'd0, out_valid}, 32'd1);

        // Back-to-back with EX/MEM forwarding of a stale rs1
        send(ALU_ADD, 5'd10, 32'd5, 5'd0, 32'h0, 32'd3, 1'b1, 5'd1, 1'b1, 32'd8, 1);
        send(ALU_SUB, 5'd1, 32'd0, 5'd0, 32'h0, 32'd1, 1'b1, 5'd2, 1'b1, 32'd7, 1);

        // Shift-amount masking and compares
        send(ALU_SLL,  5'd13, 32'd1, 5'd14, 32'h25,        32'h0, 1'b0, 5'd7, 1'b1, 32'h20, 1);
        send(ALU_SLTU, 5'd13, 32'd1, 5'd14, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd8, 1'b1, 32'd1,  1);
        send(ALU_SLT,  5'd13, 32'd1, 5'd14, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd9, 1'b1, 32'd0,  1);
        send(ALU_SRL,  5'd20, 32'h8000_0000, 5'd0, 32'h0, 32'd4, 1'b1, 5'd10, 1'b1, 32'h0800_0000, 1);
        send(ALU_AND,  5'd20, 32'hFF00_FF00, 5'd0, 32'h0, 32'h0FF0_0FF0, 1'b1, 5'd11, 1'b1, 32'h0F00_0F00, 1);
        // Unassigned op code -> 0; rd=x0 write is dropped
        send(alu_op_e'(4'd12), 5'd20, 32'd5, 5'd0, 32'h0, 32'd7, 1'b1, 5'd12, 1'b1, 32'd0, 1);
        send(ALU_ADD, 5'd21, 32'd9, 5'd0, 32'h0, 32'd1, 1'b1, 5'd0, 1'b1, 32'd10, 1);

        // Forwarding priority: EX/MEM x3=0xAA beats WB x3=0xBB
        send(ALU_ADD, 5'd0, 32'h77, 5'd0, 32'h0, 32'hAA, 1'b1, 5'd3, 1'b1, 32'hAA, 1);
        wb_wen = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'hBB;
        send(ALU_ADD, 5'd3, 32'h11, 5'd0, 32'h0, 32'h0, 1'b1, 5'd13, 1'b1, 32'hAA, 1);
        // WB-only forwarding
        wb_rd_addr = 5'd7; wb_data = 32'h1234;
        send(ALU_ADD, 5'd7, 32'h0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd14, 1'b1, 32'h1234, 1);
        // rs2 forwarding from EX/MEM (x14=0x1234): 0x2000-0x1234
        wb_wen = 1'b0;
        send(ALU_SUB, 5'd22, 32'h2000, 5'd14, 32'h0, 32'h0, 1'b0, 5'd16, 1'b1, 32'h0DCC, 1);
        // x0 never forwarded, even from WB
        wb_wen = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'h55;
        send(ALU_ADD, 5'd0, 32'h99, 5'd0, 32'h0, 32'h0, 1'b1, 5'd15, 1'b1, 32'h0, 1);
        wb_wen = 1'b0;

        // Stall: A held for 3 cycles while B waits
        drain();
        out_ready = 1'b0;
        send(ALU_XOR, 5'd11, 32'h0000_F0F0, 5'd12, 32'h0000_0FF0, 32'h0, 1'b0, 5'd5, 1'b1, 32'h0000_FF00, 1);
        alu_op = ALU_OR; rs1_addr = 5'd11; rs1_data = 32'h0000_F000;
        rs2_addr = 5'd12; rs2_data = 32'h0000_000F; use_imm = 1'b0;
        rd_addr = 5'd6; rd_wen = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result", result, 32'h0000_FF00);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        sb.push_back('{res: 32'h0000_F00F, rd: 5'd6, wen: 1'b1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_stall_capture", result, 32'h0000_F00F);

        // Flush while FULL with an incoming bundle
        drain();
        out_ready = 1'b0;
        send(ALU_ADD, 5'd23, 32'h100, 5'd0, 32'h0, 32'h1, 1'b1, 5'd17, 1'b1, 32'h101, 0);
        alu_op = ALU_ADD; rs1_addr = 5'd23; rs1_data = 32'h200; imm = 32'h2; use_imm = 1'b1;
        rd_addr = 5'd18; rd_wen = 1'b1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("preflush_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("flush_no_capture", {31'd0, out_valid}, 32'd0);

        // Reset mid-transfer discards the held instruction
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(ALU_OR, 5'd24, 32'hDEAD_0000, 5'd0, 32'h0, 32'h0000_BEEF, 1'b1, 5'd19, 1'b1, 32'hDEAD_BEEF, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_rd_wen", {31'd0, rd_wen_out}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(ALU_ADD, 5'd25, 32'd40, 5'd0, 32'h0, 32'd2, 1'b1, 5'd20, 1'b1, 32'd42, 1);

        drain();
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_ex_stage
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Registered execute stage of the RV32I pipeline. It accepts one decoded instruction per handshake from the ID/EX side and resolves operand forwarding. It computes the ALU result, using the arithmetic/logical shifters for shift ops, and holds the result in the EX/MEM register with valid/ready flow control, stall and flush.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  ID/EX bundle valid.
- in_ready_o  out  1  stage can accept the bundle this cycle.
- alu_op_i  in  4  ALU operation, type alu_op_e.
- rs1_addr_i, rs2_addr_i  in  REG_AW  source register addresses, used for forwarding.
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data.
- imm_i  in  XLEN  sign-extended immediate.
- use_imm_i  in  1  operand B = imm_i instead of rs2.
- rd_addr_i  in  REG_AW  destination register.
- rd_wen_i  in  1  instruction writes rd.
- wb_wen_i, wb_rd_addr_i, wb_data_i  in  1/REG_AW/XLEN  writeback-stage forwarding source.
- flush_i  in  1  kill the held and incoming instruction.
- out_valid_o  out  1  EX/MEM register valid.
- out_ready_i  in  1  MEM stage accepts.
- result_o  out  XLEN  registered ALU result.
- rd_addr_o, rd_wen_o  out  REG_AW/1  registered destination.

## Operation
Forwarding is combinational and is evaluated per source (rs1, rs2):
- Address 0 always reads 0; it is never forwarded.
- Priority 1: if out_valid_o && rd_wen_o && rd_addr_o==rsX, use result_o.
- Priority 2: else if wb_wen_i && wb_rd_addr_i==rsX, use wb_data_i.
- Otherwise use rsX_data_i.

Operands:
- A = forwarded rs1.
- B = use_imm_i ? imm_i : forwarded rs2.

ALU ops (alu_op_e):
- ADD=0 and SUB=1: modulo 2^32.
- SLL=2.
- SLT=3: signed compare; result is 1 or 0.
- SLTU=4: unsigned compare; result is 1 or 0.
- XOR=5.
- SRL=6.
- SRA=7.
- OR=8.
- AND=9.
- Codes 10–15: result 0, still handshaken normally.

Shift rules:
- The shift amount is B[4:0] only. Bits B[31:5] are zeroed before reaching the shifters, so B=0x25 shifts by 5.
- SRA replicates bit 31.

Pipeline-register states (implicit two-state FSM on out_valid_o):
- EMPTY: in_ready_o=1. in_valid_i && !flush_i captures the bundle and moves to FULL.
- FULL:
  - in_ready_o = out_ready_i.
  - out_ready_i && in_valid_i && !flush_i: capture the new bundle and stay FULL.
  - out_ready_i && !in_valid_i: go to EMPTY.
  - !out_ready_i: hold every output unchanged (stall).
- flush_i in any state: next state is EMPTY and nothing is captured. flush_i does not gate in_ready_o.

Boundary conditions:
- A bundle with rd_wen_i=1 and rd_addr_i=0 is registered with rd_wen_o forced to 0.
- Forwarding from result_o while stalled is legal, because no capture occurs.
- WB and EX/MEM targeting the same register: EX/MEM wins.
- Reset mid-transfer discards the held instruction.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N appears on the outputs after edge N.
- Throughput is 1 per cycle while out_ready_i=1.
- in_ready_o depends combinationally on out_valid_o and out_ready_i only.
- Reset values: out_valid_o=0, result_o=0, rd_addr_o=0, rd_wen_o=0.
- in_ready_o=1 during and after reset.
- Outputs are stable while out_valid_o && !out_ready_i.

## Structure
- Package ex_pkg holds the alu_op_e enum (4-bit) and constant SHAMT_W=5.
- Natural sub-module: alu_core, the combinational op mux that instantiates the existing left, logical-right and arithmetic-right shifters.
- ex_stage contains the forwarding muxes, the operand-B select and the EX/MEM register.

## Test plan
- Reset, then bundle SRA with A=0x8000_0000 and imm=0x1F (use_imm=1) -> next cycle result_o=0xFFFF_FFFF, out_valid_o=1.
- Back-to-back ADD x1=5+3, then SUB x2=x1-1 with stale rs1_data=0 -> second result_o=7, via EX/MEM forwarding.
- Stall: hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, result_o unchanged; release -> next bundle captured one cycle later.
- Shift masking: SLL with A=1 and B=0x0000_0025 -> result_o=0x20. SLTU 1 vs 0xFFFF_FFFF -> 1. SLT 1 vs 0xFFFF_FFFF -> 0.
- flush_i asserted while FULL with in_valid_i=1 -> out_valid_o=0 next cycle; the incoming bundle is not captured.
- Same rd=x3 in EX/MEM (0xAA) and WB (0xBB); rs1=x3 -> EX/MEM value 0xAA used. rs1=x0 with wb_rd_addr_i=0 and wb_data_i=0x55 -> operand 0.
